// File: rtl/cv32e40p_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40p_pkg
// Brief    : Shared types and helpers for the CV32E40P fetch aligner.
// Revision : 1.0
// ============================================================================
package cv32e40p_pkg;

    typedef enum logic [1:0] {
        ALIGNED    = 2'd0,
        MISALIGNED = 2'd1,
        BRANCH_MIS = 2'd2
    } aligner_state_e;

    // Low opcode bits that mark an uncompressed 32-bit instruction.
    localparam logic [1:0]  c_OPC_32BIT = 2'b11;
    localparam logic [31:0] c_PC_INC_16 = 32'd2;
    localparam logic [31:0] c_PC_INC_32 = 32'd4;

    function automatic logic f_is_compressed(input logic [1:0] i_opc);
        return (i_opc != c_OPC_32BIT);
    endfunction

endpackage : cv32e40p_pkg
`default_nettype wire

// File: rtl/cv32e40p_fetch_aligner.sv
`default_nettype none
// ============================================================================
// Module   : cv32e40p_fetch_aligner
// Brief    : Splits word-aligned fetch words into 16/32-bit instructions for ID.
// Revision : 1.0
// ============================================================================
module cv32e40p_fetch_aligner
    import cv32e40p_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic [31:0] fetch_rdata_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_aligned_o,
    output logic        is_compressed_o,
    output logic [31:0] pc_o,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i
);

    aligner_state_e r_state;
    aligner_state_e w_state_next;
    logic [31:0]    r_pc;
    logic [31:0]    w_pc_next;
    logic [15:0]    r_half;
    logic [15:0]    w_half_next;

    logic [31:0]    w_instr;
    logic           w_valid;
    logic           w_ready;
    logic           w_handshake;
    logic           w_word_xfer;
    logic [31:0]    w_branch_pc;

    assign w_branch_pc = branch_addr_i & 32'hFFFF_FFFE;

    // ------------------------------------------------------------------
    // Output datapath: selects the instruction and raw handshake signals
    // from the current state; reset and branch override them afterwards.
    // ------------------------------------------------------------------
    always_comb begin
        w_instr = fetch_rdata_i;
        w_valid = 1'b0;
        w_ready = 1'b0;

        case (r_state)
            ALIGNED: begin
                w_valid = fetch_valid_i;
                w_ready = instr_ready_i;
                if (f_is_compressed(fetch_rdata_i[1:0])) begin
                    w_instr = {16'h0000, fetch_rdata_i[15:0]};
                end
            end
            MISALIGNED: begin
                if (f_is_compressed(r_half[1:0])) begin
                    // Whole instruction already buffered: no new word needed.
                    w_instr = {16'h0000, r_half};
                    w_valid = 1'b1;
                    w_ready = 1'b0;
                end else begin
                    w_instr = {fetch_rdata_i[15:0], r_half};
                    w_valid = fetch_valid_i;
                    w_ready = instr_ready_i;
                end
            end
            BRANCH_MIS: begin
                w_valid = 1'b0;
                w_ready = 1'b1;
            end
            default: begin
                w_valid = 1'b0;
                w_ready = 1'b0;
            end
        endcase

        if (!rst_ni || branch_i) begin
            w_valid = 1'b0;
            w_ready = 1'b0;
        end
    end

    assign instr_aligned_o = w_instr;
    assign is_compressed_o = f_is_compressed(w_instr[1:0]);
    assign instr_valid_o   = w_valid;
    assign fetch_ready_o   = w_ready;
    assign pc_o            = r_pc;

    assign w_handshake = w_valid & instr_ready_i;
    assign w_word_xfer = fetch_valid_i & w_ready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_half_next  = r_half;

        if (branch_i) begin
            w_pc_next    = w_branch_pc;
            w_half_next  = 16'h0000;
            w_state_next = branch_addr_i[1] ? BRANCH_MIS : ALIGNED;
        end else begin
            case (r_state)
                ALIGNED: begin
                    if (w_handshake) begin
                        if (f_is_compressed(fetch_rdata_i[1:0])) begin
                            w_half_next  = fetch_rdata_i[31:16];
                            w_pc_next    = r_pc + c_PC_INC_16;
                            w_state_next = MISALIGNED;
                        end else begin
                            w_pc_next    = r_pc + c_PC_INC_32;
                        end
                    end
                end
                MISALIGNED: begin
                    if (w_handshake) begin
                        if (f_is_compressed(r_half[1:0])) begin
                            w_pc_next    = r_pc + c_PC_INC_16;
                            w_state_next = ALIGNED;
                        end else begin
                            w_half_next  = fetch_rdata_i[31:16];
                            w_pc_next    = r_pc + c_PC_INC_32;
                        end
                    end
                end
                BRANCH_MIS: begin
                    // Lower half precedes the target and is dropped.
                    if (w_word_xfer) begin
                        w_half_next  = fetch_rdata_i[31:16];
                        w_state_next = MISALIGNED;
                    end
                end
                default: begin
                    w_state_next = ALIGNED;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= ALIGNED;
            r_pc    <= RESET_PC;
            r_half  <= 16'h0000;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_half  <= w_half_next;
        end
    end

endmodule : cv32e40p_fetch_aligner
`default_nettype wire

// File: tb/tb_cv32e40p_fetch_aligner.sv
`default_nettype none
// ============================================================================
// Module   : tb_cv32e40p_fetch_aligner
// Brief    : Directed self-checking bench for the fetch aligner.
// Revision : 1.0
// ============================================================================
module tb_cv32e40p_fetch_aligner;

    localparam logic [31:0] c_RESET_PC = 32'h0000_1000;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        fetch_valid_i;
    logic        fetch_ready_o;
    logic [31:0] fetch_rdata_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_aligned_o;
    logic        is_compressed_o;
    logic [31:0] pc_o;
    logic        branch_i;
    logic [31:0] branch_addr_i;

    int total = 0;
    int bad   = 0;

    cv32e40p_fetch_aligner #(
        .RESET_PC (c_RESET_PC)
    ) u_dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .fetch_valid_i   (fetch_valid_i),
        .fetch_ready_o   (fetch_ready_o),
        .fetch_rdata_i   (fetch_rdata_i),
        .instr_valid_o   (instr_valid_o),
        .instr_ready_i   (instr_ready_i),
        .instr_aligned_o (instr_aligned_o),
        .is_compressed_o (is_compressed_o),
        .pc_o            (pc_o),
        .branch_i        (branch_i),
        .branch_addr_i   (branch_addr_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full instruction-side view of one presented instruction.
    task automatic chk_instr(input string tag, input logic [31:0] instr,
                             input logic [31:0] pc, input logic comp,
                             input logic fready);
        chk({tag, ".valid"}, {31'd0, instr_valid_o},   32'd1);
        chk({tag, ".instr"}, instr_aligned_o,          instr);
        chk({tag, ".pc"},    pc_o,                     pc);
        chk({tag, ".comp"},  {31'd0, is_compressed_o}, {31'd0, comp});
        chk({tag, ".frdy"},  {31'd0, fetch_ready_o},   {31'd0, fready});
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_branch(input logic [31:0] addr);
        branch_i      = 1'b1;
        branch_addr_i = addr;
        #2;
        chk("br.valid", {31'd0, instr_valid_o}, 32'd0);
        chk("br.frdy",  {31'd0, fetch_ready_o}, 32'd0);
        tick();
        branch_i = 1'b0;
    endtask

    initial begin
        rst_ni        = 1'b0;
        fetch_valid_i = 1'b1;
        fetch_rdata_i = 32'h0000_0013;
        instr_ready_i = 1'b1;
        branch_i      = 1'b0;
        branch_addr_i = 32'h0;

        // Reset: handshakes forced off even with both sides willing.
        tick();
        #2;
        chk("rst.pc",    pc_o,                     c_RESET_PC);
        chk("rst.valid", {31'd0, instr_valid_o},   32'd0);
        chk("rst.frdy",  {31'd0, fetch_ready_o},   32'd0);
        chk("rst.instr", instr_aligned_o,          32'h0000_0013);
        rst_ni = 1'b1;

        // Stream of 32-bit NOPs after branch to 0x80.
        do_branch(32'h0000_0080);
        #2; chk_instr("nop0", 32'h0000_0013, 32'h0000_0080, 1'b0, 1'b1);
        tick(); #2; chk_instr("nop1", 32'h0000_0013, 32'h0000_0084, 1'b0, 1'b1);
        tick(); #2; chk_instr("nop2", 32'h0000_0013, 32'h0000_0088, 1'b0, 1'b1);
        tick();

        // Two compressed instructions in one word.
        do_branch(32'h0000_0100);
        fetch_rdata_i = 32'h4505_4501;
        #2; chk_instr("cc0", 32'h0000_4501, 32'h0000_0100, 1'b1, 1'b1);
        tick();
        fetch_valid_i = 1'b0;
        #2; chk_instr("cc1", 32'h0000_4505, 32'h0000_0102, 1'b1, 1'b0);
        tick();
        #2; chk("cc.pc_after", pc_o, 32'h0000_0104);
        chk("cc.nofetch", {31'd0, instr_valid_o}, 32'd0);

        // Compressed, then a straddling 32-bit instruction, with a stall.
        fetch_valid_i = 1'b1;
        do_branch(32'h0000_0100);
        fetch_rdata_i = 32'h0513_4501;
        #2; chk_instr("st0", 32'h0000_4501, 32'h0000_0100, 1'b1, 1'b1);
        tick();
        fetch_rdata_i = 32'hABCD_0010;
        #2; chk_instr("st1", 32'h0010_0513, 32'h0000_0102, 1'b0, 1'b1);
        instr_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2; chk_instr("stall", 32'h0010_0513, 32'h0000_0102, 1'b0, 1'b0);
            tick();
        end
        instr_ready_i = 1'b1;
        #2; chk_instr("st1r", 32'h0010_0513, 32'h0000_0102, 1'b0, 1'b1);
        tick();
        fetch_valid_i = 1'b0;
        #2; chk_instr("st2", 32'h0000_ABCD, 32'h0000_0106, 1'b1, 1'b0);
        tick();
        #2; chk("st.pc_after", pc_o, 32'h0000_0108);

        // Branch to odd halfword target: bit 0 ignored, lower half dropped.
        fetch_valid_i = 1'b1;
        do_branch(32'h0000_0207);
        fetch_rdata_i = 32'h4585_1234;
        #2;
        chk("bm.valid", {31'd0, instr_valid_o}, 32'd0);
        chk("bm.frdy",  {31'd0, fetch_ready_o}, 32'd1);
        chk("bm.pc",    pc_o,                   32'h0000_0206);
        tick();
        fetch_valid_i = 1'b0;
        #2; chk_instr("bm0", 32'h0000_4585, 32'h0000_0206, 1'b1, 1'b0);

        // Branch coincident with a would-be handshake: no PC advance.
        do_branch(32'h0000_0300);
        fetch_valid_i = 1'b1;
        fetch_rdata_i = 32'h0000_0013;
        #2; chk_instr("bh0", 32'h0000_0013, 32'h0000_0300, 1'b0, 1'b1);
        tick();

        // Reset while a straddle half is buffered.
        do_branch(32'h0000_0400);
        fetch_rdata_i = 32'h0513_4501;
        tick();
        #2; chk("rm.pc_mis", pc_o, 32'h0000_0402);
        rst_ni = 1'b0;
        #1;
        chk("rm.valid", {31'd0, instr_valid_o}, 32'd0);
        chk("rm.frdy",  {31'd0, fetch_ready_o}, 32'd0);
        tick();
        rst_ni        = 1'b1;
        fetch_valid_i = 1'b0;
        #2;
        chk("rm.pc",    pc_o,                   c_RESET_PC);
        chk("rm.valid2",{31'd0, instr_valid_o}, 32'd0);
        fetch_valid_i = 1'b1;
        fetch_rdata_i = 32'h0000_0013;
        #1; chk_instr("rm0", 32'h0000_0013, c_RESET_PC, 1'b0, 1'b1);
        tick();

        // PC wrap from 0xFFFF_FFFE to 0.
        do_branch(32'hFFFF_FFFE);
        fetch_rdata_i = 32'h4585_1234;
        tick();
        fetch_valid_i = 1'b0;
        #2; chk_instr("wr0", 32'h0000_4585, 32'hFFFF_FFFE, 1'b1, 1'b0);
        tick();
        #2; chk("wr.pc", pc_o, 32'h0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_cv32e40p_fetch_aligner
`default_nettype wire
